// File: rtl/coil_pwm_driver.sv
// Stepper coil gate driver. Each coil change starts a full-strength BOOST window,
// then the drive drops to a reduced HOLD duty. Illegal patterns and en=0 blank the coils.
module coil_pwm_driver #(
    parameter int PWM_PERIOD   = 100,
    parameter int BOOST_DUTY   = 100,
    parameter int HOLD_DUTY    = 30,
    parameter int BOOST_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coils_in,
    input  logic       en,
    output logic [3:0] coils_out,
    output logic       boost,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_BOOST = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    // A duty at or above the period is clamped to the period so it stays "always on" in 8 bits
    localparam logic [7:0]  PWM_LAST    = 8'(PWM_PERIOD - 1);
    localparam logic [7:0]  BOOST_DUTY8 = 8'((BOOST_DUTY >= PWM_PERIOD) ? PWM_PERIOD : BOOST_DUTY);
    localparam logic [7:0]  HOLD_DUTY8  = 8'((HOLD_DUTY >= PWM_PERIOD) ? PWM_PERIOD : HOLD_DUTY);
    localparam logic [15:0] BOOST_LOAD  = 16'(BOOST_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  coil_q, coil_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [15:0] boost_cnt_q, boost_cnt_d;
    logic [7:0]  duty_q, duty_d;
    logic [3:0]  coils_out_q, coils_out_d;
    logic        fault_q, fault_d;

    logic        change;
    logic        boost_entry;
    logic        pwm_wrap;
    logic        pwm_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            coil_q      <= 4'b0000;
            pwm_cnt_q   <= 8'd0;
            boost_cnt_q <= 16'd0;
            duty_q      <= 8'd0;
            coils_out_q <= 4'b0000;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            coil_q      <= coil_d;
            pwm_cnt_q   <= pwm_cnt_d;
            boost_cnt_q <= boost_cnt_d;
            duty_q      <= duty_d;
            coils_out_q <= coils_out_d;
            fault_q     <= fault_d;
        end
    end

    // Disable wins over a simultaneous step; a step on the last BOOST cycle reloads the window
    always_comb begin
        change      = en && (coils_in != coil_q);
        state_d     = state_q;
        boost_entry = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d     = ST_BOOST;
                    boost_entry = 1'b1;
                end
                ST_BOOST: begin
                    if (change) begin
                        boost_entry = 1'b1;
                    end else if (boost_cnt_q == 16'd1) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (change) begin
                        state_d     = ST_BOOST;
                        boost_entry = 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Duty only changes at a period wrap (or BOOST entry) so pulses are never truncated
    always_comb begin
        coil_d      = coils_in;
        pwm_wrap    = (pwm_cnt_q == PWM_LAST);
        pwm_cnt_d   = pwm_wrap ? 8'd0 : pwm_cnt_q + 8'd1;
        duty_d      = duty_q;
        boost_cnt_d = boost_cnt_q;
        if (boost_entry) begin
            pwm_cnt_d   = 8'd0;
            duty_d      = BOOST_DUTY8;
            boost_cnt_d = BOOST_LOAD;
        end else if (state_d == ST_OFF) begin
            pwm_cnt_d = 8'd0;
            duty_d    = 8'd0;
        end else begin
            if (state_q == ST_BOOST && boost_cnt_q != 16'd0) begin
                boost_cnt_d = boost_cnt_q - 16'd1;
            end
            if (pwm_wrap) begin
                duty_d = (state_d == ST_HOLD) ? HOLD_DUTY8 : BOOST_DUTY8;
            end
        end
    end

    always_comb begin
        pwm_on      = (pwm_cnt_q < duty_q);
        fault_d     = !((coil_q != 4'b0000) && ((coil_q & (coil_q - 4'd1)) == 4'b0000));
        coils_out_d = (state_q != ST_OFF && !fault_d && pwm_on) ? coil_q : 4'b0000;
        coils_out   = coils_out_q;
        boost       = (state_q == ST_BOOST);
        fault       = fault_q;
    end

endmodule
